complex_product_combiner: RTL
=============================

COMPLEX_PRODUCT_COMBINER -- requirements
Module: complex_product_combiner

Interface
REQ-001 Parameter: DATA_W, default 32, width of the product stream and of out0.
REQ-002 Parameter: LEN_W, default 10, width of the element-count configuration.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 run  input  1  single-cycle start pulse, shared with the other Versat units.
REQ-006 done  output  1  high while idle; low from the cycle after an accepted run until the operation completes.
REQ-007 in0  input  DATA_W  partial-product stream from the upstream Mul unit.
REQ-008 delay0  input  32  cycles to wait after run before in0 carries the first product.
REQ-009 length  input  LEN_W  number of complex elements; each element is 4 products.
REQ-010 acc_en  input  1  1 = accumulate across elements (complex dot product); 0 = per-element result.
REQ-011 out0  output  DATA_W  combined real/imag result, registered.
REQ-012 out_valid  output  1  one-cycle pulse when out0 takes a new value.

Function
REQ-013 Per element, the products arrive in the order p0=ar*br, p1=ai*bi, p2=ar*bi, p3=ai*br, one per cycle, with no gaps.
REQ-014 States: IDLE, DELAY, RUN. All other encodings return to IDLE.
REQ-015 In IDLE with run=1, the block latches delay0, length and acc_en, clears both accumulators and the phase counter, and drops done.
REQ-016 Config inputs are sampled only at the accepted run; later changes have no effect on the active operation.
REQ-017 With delay0=D, product k (k=0..4*length-1) is sampled from in0 at cycle T+1+D, where run is high at cycle T.
REQ-018 DELAY counts down D cycles; when D=0, the block enters RUN directly.
REQ-019 A 2-bit phase counter advances on each sampled product and wraps 3->0.
REQ-020 On phase 1: real = p0 - p1, with p0 held in an internal register.
REQ-021 On phase 3: imag = p2 + p3, with p2 held in an internal register.
REQ-022 acc_en=0 -> out0 <= real or imag; acc_en=1 -> accR += real or accI += imag, and out0 <= the updated accumulator.
REQ-023 out0 and out_valid update in the cycle after p1 is sampled (real) and after p3 is sampled (imag); out0 holds its value between updates.
REQ-024 All arithmetic is DATA_W-bit two's complement and wraps modulo 2^DATA_W; there is no saturation and no overflow flag.
REQ-025 After the last product (phase 3 of element length-1) is sampled, the block returns to IDLE and done rises in the same cycle that the final out_valid is asserted.
REQ-026 length=0: the block does not enter RUN, done returns high at T+2+D, and out0 and out_valid are unchanged.
REQ-027 run while DELAY or RUN is ignored; the operation in progress is not disturbed.
REQ-028 run in the same cycle that done rises is ignored; run is accepted only when done is already high.
REQ-029 in0 is ignored outside RUN.

Reset
REQ-030 While rst=1: state=IDLE, done=1, out0=0, out_valid=0, accumulators, phase counter, delay counter, element counter and latched config = 0.
REQ-031 rst asserted mid-operation aborts the operation at the next edge with the REQ-030 values; no further out_valid pulses occur.
REQ-032 rst has priority over run in the same cycle.

Verification
REQ-033 Per-element: D=0, length=1, acc_en=0, in0 = 6,2,5,3.
- done falls at T+1.
- out0=4 with out_valid at T+3.
- out0=8 with out_valid at T+5.
- done rises at T+5.
REQ-034 Delay: D=3, same data as REQ-033.
- First sample at T+4.
- real=4 at T+6, imag=8 at T+8.
REQ-035 Accumulate: acc_en=1, length=2, elements (6,2,5,3) and (1,4,2,2).
- out0 sequence: 4, 8, 1, 12.
- Four out_valid pulses.
REQ-036 Wrap and boundaries:
- acc_en=0, p0=0x7FFFFFFF, p1=0xFFFFFFFF -> real=0x80000000.
- length=0, D=0 -> done low at T+1 only, no out_valid.
REQ-037 Control conflicts:
- Second run pulse during RUN -> ignored; results are identical to REQ-033.
- rst at T+3 of REQ-033 -> out0=0 and done=1 at T+4; no out_valid afterwards.

Source files
------------

// File: rtl/complex_product_combiner.sv
// Combines the p0..p3 partial-product stream of a complex multiply into real/imag results,
// either per element or accumulated across elements as a complex dot product.
module complex_product_combiner #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              done,
    input  logic [DATA_W-1:0] in0,
    input  logic [31:0]       delay0,
    input  logic [LEN_W-1:0]  length,
    input  logic              acc_en,
    output logic [DATA_W-1:0] out0,
    output logic              out_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

    state_t            state, stateNext;
    logic              lastIdle;
    logic              accept;
    logic [31:0]       delayCnt;
    logic [LEN_W-1:0]  elemCnt;
    logic              accEnQ;
    logic [1:0]        phase;
    logic [DATA_W-1:0] holdP;
    logic [DATA_W-1:0] accR, accI;
    logic [DATA_W-1:0] partSum, accNew;

    // A run is taken only if the block was already idle in the previous cycle,
    // so a pulse coinciding with done rising is dropped.
    assign accept = (state == IDLE) && lastIdle && run;
    assign done   = (state == IDLE);

    assign partSum = phase[1] ? (holdP + in0) : (holdP - in0);
    assign accNew  = (phase[1] ? accI : accR) + partSum;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if ((delay0 == 32'd0) && (length != '0)) stateNext = RUN;
                    else                                     stateNext = DELAY;
                end
            end
            DELAY: begin
                // A zero-length operation drains the full delay plus one cycle, then idles.
                if (delayCnt == 32'd0)                              stateNext = IDLE;
                else if ((delayCnt == 32'd1) && (elemCnt != '0))    stateNext = RUN;
            end
            RUN: begin
                if ((phase == 2'd3) && (elemCnt == ONE_LEN)) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lastIdle  <= 1'b1;
            delayCnt  <= '0;
            elemCnt   <= '0;
            accEnQ    <= 1'b0;
            phase     <= '0;
            holdP     <= '0;
            accR      <= '0;
            accI      <= '0;
            out0      <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= stateNext;
            lastIdle  <= (state == IDLE);
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        delayCnt <= delay0;
                        elemCnt  <= length;
                        accEnQ   <= acc_en;
                        accR     <= '0;
                        accI     <= '0;
                        phase    <= '0;
                    end
                end
                DELAY: begin
                    if (delayCnt != 32'd0) delayCnt <= delayCnt - 32'd1;
                end
                RUN: begin
                    phase <= phase + 2'd1;
                    if (!phase[0]) begin
                        holdP <= in0;
                    end else begin
                        out_valid <= 1'b1;
                        if (accEnQ) begin
                            out0 <= accNew;
                            if (phase[1]) accI <= accNew;
                            else          accR <= accNew;
                        end else begin
                            out0 <= partSum;
                        end
                        if (phase[1]) elemCnt <= elemCnt - ONE_LEN;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
